// File: rtl/irq_sequencer_if.sv
// Handshake and configuration bundle between the interrupt sequencer and the CPU core.
// The slave modport is the sequencer; the master modport is the control unit/datapath side.
interface irq_sequencer_if #(
  parameter int unsigned NIRQ  = 4,
  parameter int unsigned VEC_W = 10
);
  logic [NIRQ-1:0]  irq_in;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [7:0]       cfg_wdata;
  logic [7:0]       cfg_rdata;
  logic             int_req;
  logic             int_ack;
  logic             int_ret;
  logic [VEC_W-1:0] int_vec;
  logic [1:0]       active_id;
  logic             in_service;
  logic [NIRQ-1:0]  pending;

  modport master (
    output irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, int_ret,
    input  cfg_rdata, int_req, int_vec, active_id, in_service, pending
  );

  modport slave (
    input  irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, int_ret,
    output cfg_rdata, int_req, int_vec, active_id, in_service, pending
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: edge-latched pending bits, mask/enable, fixed priority,
// request/ack/return handshake with the control unit and vector generation.
module irq_sequencer #(
  parameter int unsigned      NIRQ       = 4,
  parameter int unsigned      VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(10'h3F0),
  parameter int unsigned      VEC_STRIDE = 4
) (
  input logic            clk,
  input logic            reset,
  irq_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  localparam int unsigned ID_W = 2;

  state_t          state, state_next;
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] pending, pending_next;
  logic [NIRQ-1:0] mask;
  logic            enable;
  logic [ID_W-1:0] active_id, active_next;
  logic [ID_W-1:0] winner;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] set_bits, clr_bits;
  logic            wr_mask, wr_en, wr_clr, wr_set;
  logic            ack_take;

  assign wr_mask  = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_en    = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign wr_clr   = bus.cfg_we && (bus.cfg_addr == 2'd2);
  assign wr_set   = bus.cfg_we && (bus.cfg_addr == 2'd3);
  assign ack_take = (state == REQ) && bus.int_ack;

  // Sets are applied after clears so a simultaneous set wins.
  always_comb begin
    set_bits = bus.irq_in & ~irq_prev;
    clr_bits = '0;
    if (wr_set) set_bits = set_bits | bus.cfg_wdata[NIRQ-1:0];
    if (wr_clr) clr_bits = bus.cfg_wdata[NIRQ-1:0];
    if (ack_take) clr_bits = clr_bits | (NIRQ'(1) << active_id);
    pending_next = (pending & ~clr_bits) | set_bits;
  end

  assign eligible = pending & mask & {NIRQ{enable}};

  // Lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_next  = state;
    active_next = active_id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next  = REQ;
          active_next = winner;
        end
      end
      REQ: begin
        if (bus.int_ack)               state_next = SVC;
        else if (!eligible[active_id]) state_next = IDLE;
      end
      SVC: begin
        if (bus.int_ret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      active_id <= '0;
      irq_prev  <= '0;
      pending   <= '0;
      mask      <= '0;
      enable    <= 1'b0;
    end else begin
      state     <= state_next;
      active_id <= active_next;
      irq_prev  <= bus.irq_in;
      pending   <= pending_next;
      if (wr_mask) mask   <= bus.cfg_wdata[NIRQ-1:0];
      if (wr_en)   enable <= bus.cfg_wdata[0];
    end
  end

  // Readback is combinational; pending is visible at both clear and set addresses.
  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = 8'(mask);
      2'd1:    bus.cfg_rdata = 8'(enable);
      default: bus.cfg_rdata = 8'(pending);
    endcase
  end

  assign bus.int_req    = (state == REQ);
  assign bus.in_service = (state == SVC);
  assign bus.active_id  = active_id;
  assign bus.pending    = pending;
  assign bus.int_vec    = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(active_id);

  if (NIRQ < 8) begin : g_wdata_unused
    logic wdata_hi_unused;
    assign wdata_hi_unused = ^bus.cfg_wdata[7:NIRQ];
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a vector table for the main flow plus
// hand-written sequences for vector wrap-around and reset while in service.
module tb_irq_sequencer;

  logic clk = 1'b0;
  logic reset1, reset2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  irq_sequencer_if #(.NIRQ(4), .VEC_W(10)) bus1 ();
  irq_sequencer_if #(.NIRQ(4), .VEC_W(10)) bus2 ();

  irq_sequencer #(.NIRQ(4), .VEC_W(10), .VEC_BASE(10'h3F0), .VEC_STRIDE(4)) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1.slave)
  );
  irq_sequencer #(.NIRQ(4), .VEC_W(10), .VEC_BASE(10'h3FC), .VEC_STRIDE(4)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2.slave)
  );

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [3:0] irq;
    logic       ack;
    logic       ret;
    logic       req;
    logic       svc;
    logic [1:0] id;
    logic [9:0] vec;
    logic [3:0] pend;
    logic [7:0] rd;
  } row_t;

  row_t rows[$];

  function automatic void add(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                              input logic [3:0] irq, input logic ack, input logic ret,
                              input logic req, input logic svc, input logic [1:0] id,
                              input logic [9:0] vec, input logic [3:0] pend, input logic [7:0] rd);
    row_t r;
    r.we = we; r.addr = addr; r.wd = wd; r.irq = irq; r.ack = ack; r.ret = ret;
    r.req = req; r.svc = svc; r.id = id; r.vec = vec; r.pend = pend; r.rd = rd;
    rows.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive1(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                        input logic [3:0] irq, input logic ack, input logic ret);
    bus1.cfg_we = we; bus1.cfg_addr = addr; bus1.cfg_wdata = wd;
    bus1.irq_in = irq; bus1.int_ack = ack; bus1.int_ret = ret;
  endtask

  task automatic drive2(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                        input logic [3:0] irq, input logic ack, input logic ret);
    bus2.cfg_we = we; bus2.cfg_addr = addr; bus2.cfg_wdata = wd;
    bus2.irq_in = irq; bus2.int_ack = ack; bus2.int_ret = ret;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic svc, input logic [1:0] id,
                         input logic [9:0] vec, input logic [3:0] pend, input logic [7:0] rd,
                         input logic sel);
    if (!sel) begin
      chk({tag, " int_req"},    32'(bus1.int_req),    32'(req));
      chk({tag, " in_service"}, 32'(bus1.in_service), 32'(svc));
      chk({tag, " active_id"},  32'(bus1.active_id),  32'(id));
      chk({tag, " int_vec"},    32'(bus1.int_vec),    32'(vec));
      chk({tag, " pending"},    32'(bus1.pending),    32'(pend));
      chk({tag, " cfg_rdata"},  32'(bus1.cfg_rdata),  32'(rd));
    end else begin
      chk({tag, " int_req"},    32'(bus2.int_req),    32'(req));
      chk({tag, " in_service"}, 32'(bus2.in_service), 32'(svc));
      chk({tag, " active_id"},  32'(bus2.active_id),  32'(id));
      chk({tag, " int_vec"},    32'(bus2.int_vec),    32'(vec));
      chk({tag, " pending"},    32'(bus2.pending),    32'(pend));
      chk({tag, " cfg_rdata"},  32'(bus2.cfg_rdata),  32'(rd));
    end
  endtask

  initial begin
    //   we addr wd     irq   ack ret | req svc id vec     pend  rd
    add(1, 0, 8'h0F, 4'h0, 0, 0,  0, 0, 0, 10'h3F0, 4'h0, 8'h0F); // mask = F
    add(1, 1, 8'h01, 4'h0, 0, 0,  0, 0, 0, 10'h3F0, 4'h0, 8'h01); // enable
    add(0, 0, 8'h00, 4'h4, 0, 0,  0, 0, 0, 10'h3F0, 4'h4, 8'h0F); // edge on 2
    add(0, 0, 8'h00, 4'h4, 0, 0,  1, 0, 2, 10'h3F8, 4'h4, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 2, 10'h3F8, 4'h0, 8'h0F); // ack
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 2, 10'h3F8, 4'h0, 8'h0F); // ret
    add(0, 0, 8'h00, 4'hA, 0, 0,  0, 0, 2, 10'h3F8, 4'hA, 8'h0F); // lines 3 and 1
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 1, 10'h3F4, 4'hA, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 1, 10'h3F4, 4'h8, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 1, 10'h3F4, 4'h8, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 3, 10'h3FC, 4'h8, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 3, 10'h3FC, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 3, 10'h3FC, 4'h0, 8'h0F);
    add(1, 0, 8'h00, 4'h0, 0, 0,  0, 0, 3, 10'h3FC, 4'h0, 8'h00); // mask = 0
    add(0, 0, 8'h00, 4'h1, 0, 0,  0, 0, 3, 10'h3FC, 4'h1, 8'h00);
    add(0, 0, 8'h00, 4'h0, 0, 0,  0, 0, 3, 10'h3FC, 4'h1, 8'h00);
    add(1, 0, 8'h01, 4'h0, 0, 0,  0, 0, 3, 10'h3FC, 4'h1, 8'h01); // mask = 1
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 0, 10'h3F0, 4'h1, 8'h01);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 0, 10'h3F0, 4'h0, 8'h01);
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 0, 10'h3F0, 4'h0, 8'h01);
    add(1, 0, 8'h0F, 4'h0, 0, 0,  0, 0, 0, 10'h3F0, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h4, 0, 0,  0, 0, 0, 10'h3F0, 4'h4, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 2, 10'h3F8, 4'h4, 8'h0F);
    add(1, 2, 8'h04, 4'h0, 0, 0,  1, 0, 2, 10'h3F8, 4'h0, 8'h00); // clear in REQ
    add(0, 0, 8'h00, 4'h0, 0, 0,  0, 0, 2, 10'h3F8, 4'h0, 8'h0F); // withdrawn
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 2, 10'h3F8, 4'h0, 8'h0F); // ret in IDLE
    add(0, 0, 8'h00, 4'h2, 0, 0,  0, 0, 2, 10'h3F8, 4'h2, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 1, 10'h3F4, 4'h2, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 1, 10'h3F4, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h1, 0, 0,  0, 1, 1, 10'h3F4, 4'h1, 8'h0F); // edge in SVC
    add(0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 1, 10'h3F4, 4'h1, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 1, 10'h3F4, 4'h1, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 0, 10'h3F0, 4'h1, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 0, 10'h3F0, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 0, 10'h3F0, 4'h0, 8'h0F);
    add(1, 2, 8'h08, 4'h8, 0, 0,  0, 0, 0, 10'h3F0, 4'h8, 8'h08); // set beats clear
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 3, 10'h3FC, 4'h8, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 3, 10'h3FC, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 3, 10'h3FC, 4'h0, 8'h0F); // ack in SVC
    add(0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 3, 10'h3FC, 4'h0, 8'h0F);
    add(0, 0, 8'h00, 4'h0, 1, 0,  0, 0, 3, 10'h3FC, 4'h0, 8'h0F); // ack in IDLE
    add(1, 3, 8'h04, 4'h0, 0, 0,  0, 0, 3, 10'h3FC, 4'h4, 8'h04); // sw trigger
    add(0, 0, 8'h00, 4'h0, 0, 0,  1, 0, 2, 10'h3F8, 4'h4, 8'h0F);
    add(1, 1, 8'h00, 4'h0, 0, 0,  1, 0, 2, 10'h3F8, 4'h4, 8'h00); // enable off
    add(0, 0, 8'h00, 4'h0, 0, 0,  0, 0, 2, 10'h3F8, 4'h4, 8'h0F);

    reset1 = 1'b1;
    reset2 = 1'b1;
    drive1(0, 0, 8'h00, 4'h0, 0, 0);
    drive2(0, 0, 8'h00, 4'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_all("reset1", 0, 0, 0, 10'h3F0, 4'h0, 8'h00, 1'b0);
    chk_all("reset2", 0, 0, 0, 10'h3FC, 4'h0, 8'h00, 1'b1);

    reset1 = 1'b0;
    foreach (rows[i]) begin
      drive1(rows[i].we, rows[i].addr, rows[i].wd, rows[i].irq, rows[i].ack, rows[i].ret);
      @(negedge clk);
      chk_all($sformatf("row%0d", i + 1), rows[i].req, rows[i].svc, rows[i].id,
              rows[i].vec, rows[i].pend, rows[i].rd, 1'b0);
    end
    drive1(0, 0, 8'h00, 4'h0, 0, 0);

    // Second instance: vector wrap past 2^VEC_W, then reset while in service.
    reset2 = 1'b0;
    drive2(1, 0, 8'h0F, 4'h0, 0, 0); @(negedge clk);
    drive2(1, 1, 8'h01, 4'h0, 0, 0); @(negedge clk);
    drive2(1, 3, 8'h02, 4'h0, 0, 0); @(negedge clk);
    chk_all("sw_set", 0, 0, 0, 10'h3FC, 4'h2, 8'h02, 1'b1);
    drive2(0, 0, 8'h00, 4'h0, 0, 0); @(negedge clk);
    chk_all("wrap_req", 1, 0, 1, 10'h000, 4'h2, 8'h0F, 1'b1);
    drive2(0, 0, 8'h00, 4'h0, 1, 0); @(negedge clk);
    chk_all("wrap_svc", 0, 1, 1, 10'h000, 4'h0, 8'h0F, 1'b1);
    drive2(0, 0, 8'h00, 4'h1, 0, 0);
    reset2 = 1'b1;
    @(negedge clk);
    chk_all("reset_svc", 0, 0, 0, 10'h3FC, 4'h0, 8'h00, 1'b1);

    // Line already high when reset releases counts as an edge.
    reset2 = 1'b0;
    @(negedge clk);
    chk_all("high_at_release", 0, 0, 0, 10'h3FC, 4'h1, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
